// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the fetch issue queue.
package fetch_queue_pkg;

    localparam logic [31:0] FQ_NOP          = 32'h0000_0013;
    localparam int unsigned FQ_DATA_WIDTH   = 32;
    localparam int unsigned FQ_ADDRESS_BITS = 20;

    typedef struct packed {
        logic [FQ_DATA_WIDTH-1:0]   instruction;
        logic [FQ_ADDRESS_BITS-1:0] PC;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Queue storage: DEPTH entries, one synchronous write port, one combinational read port.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter type         entry_t = fq_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  entry_t                   write_data,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output entry_t                   read_data
);

    entry_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_en) mem[write_addr] <= write_data;
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fetch_issue_queue.sv
// Fetch-to-decode instruction queue with flush and optional same-cycle bypass
// (enabled by defining FETCH_QUEUE_BYPASS_EN).
module fetch_issue_queue
    import fetch_queue_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH        = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_instruction,
    input  logic [ADDRESS_BITS-1:0]  in_PC,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_instruction,
    output logic [ADDRESS_BITS-1:0]  out_PC,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     report
);

    localparam int unsigned PW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("fetch_issue_queue: DEPTH must be a power of two and >= 2");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   instruction;
        logic [ADDRESS_BITS-1:0] PC;
    } entry_t;

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count_q;
    logic          empty, full, bypass, enq, deq, wr_en, rd_en;
    entry_t        head, wr_entry;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign in_ready = ~full;
    assign count    = count_q;
    assign wr_entry = '{instruction: in_instruction, PC: in_PC};

`ifdef FETCH_QUEUE_BYPASS_EN
    // Reset gates the bypass so outputs stay idle while reset is held.
    assign bypass = empty & in_valid & ~flush & reset;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_valid       = ~empty | bypass;
        out_instruction = DATA_WIDTH'(FQ_NOP);
        out_PC          = '0;
        if (bypass) begin
            out_instruction = in_instruction;
            out_PC          = in_PC;
        end else if (!empty) begin
            out_instruction = head.instruction;
            out_PC          = head.PC;
        end
    end

    assign enq = in_valid & ~full & ~flush;
    assign deq = out_valid & out_ready & ~flush;
    // A bypassed entry that is consumed immediately never touches storage.
    assign wr_en = enq & ~(bypass & out_ready);
    assign rd_en = deq & ~bypass;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    fq_storage #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_storage (
        .clock      (clock),
        .write_en   (wr_en),
        .write_addr (wr_ptr),
        .write_data (wr_entry),
        .read_addr  (rd_ptr),
        .read_data  (head)
    );

`ifndef SYNTHESIS
    logic [31:0] cycle_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset && report)
            $display("fq[%0d] cyc=%0d rd=%0d wr=%0d count=%0d in v/r=%b/%b out v/r=%b/%b head pc=%h insn=%h",
                     CORE, cycle_q, rd_ptr, wr_ptr, count_q, in_valid, in_ready,
                     out_valid, out_ready, out_PC, out_instruction);
    end
`endif

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Self-checking bench for fetch_issue_queue: queue-based reference model plus directed pins.
module tb_fetch_issue_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready, report;
    logic [31:0] in_instruction, out_instruction;
    logic [19:0] in_PC, out_PC;
    logic        in_ready, out_valid;
    logic [2:0]  count;

    fetch_issue_queue #(
        .CORE         (0),
        .DATA_WIDTH   (32),
        .ADDRESS_BITS (20),
        .DEPTH        (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_instruction  (in_instruction),
        .in_PC           (in_PC),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_PC          (out_PC),
        .out_ready       (out_ready),
        .count           (count),
        .report          (report)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ins;
        logic [19:0] pc;
    } ent_t;

    ent_t q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare against the model at the falling edge,
    // advance the model, then return just after the next rising edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [19:0] pc,
                        input logic ordy, input logic fl,
                        output logic seen_v, output logic [19:0] seen_pc);
        bit          empty, byp, exp_ov;
        logic [31:0] exp_ins;
        logic [19:0] exp_pc;
        ent_t        e;
        in_valid       = iv;
        in_instruction = ins;
        in_PC          = pc;
        out_ready      = ordy;
        flush          = fl;
        report         = ($urandom_range(0, 63) == 0);
        @(negedge clock);
        empty   = (q.size() == 0);
        byp     = BYP && empty && iv && !fl;
        exp_ov  = !empty || byp;
        exp_ins = byp ? ins : (!empty ? q[0].ins : NOP);
        exp_pc  = byp ? pc  : (!empty ? q[0].pc  : 20'h0);
        chk("count",           64'(count),           64'(q.size()));
        chk("in_ready",        64'(in_ready),        64'(q.size() != DEPTH));
        chk("out_valid",       64'(out_valid),       64'(exp_ov));
        chk("out_instruction", 64'(out_instruction), 64'(exp_ins));
        chk("out_PC",          64'(out_PC),          64'(exp_pc));
        seen_v  = out_valid;
        seen_pc = out_PC;
        if (fl) begin
            q.delete();
        end else if (!(byp && ordy)) begin
            bit do_enq;
            do_enq = iv && (q.size() != DEPTH);
            if (exp_ov && ordy) void'(q.pop_front());
            if (do_enq) begin
                e.ins = ins;
                e.pc  = pc;
                q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    logic        sv;
    logic [19:0] spc;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; report = 1'b0;
        in_instruction = '0; in_PC = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count",     64'(count),           64'd0);
        chk("rst_in_ready",  64'(in_ready),        64'd1);
        chk("rst_out_valid", 64'(out_valid),       64'd0);
        chk("rst_out_insn",  64'(out_instruction), 64'(NOP));
        chk("rst_out_pc",    64'(out_PC),          64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Three pushes held, then drained in order.
        step(1, 32'h0000_0093, 20'h000, 0, 0, sv, spc);
        step(1, 32'h0010_0113, 20'h004, 0, 0, sv, spc);
        step(1, 32'h0020_0193, 20'h008, 0, 0, sv, spc);
        chk("lit_count3", 64'(count), 64'd3);
        step(0, 0, 0, 1, 0, sv, spc); chk("lit_pc0", 64'(spc), 64'h000);
        step(0, 0, 0, 1, 0, sv, spc); chk("lit_pc4", 64'(spc), 64'h004);
        step(0, 0, 0, 1, 0, sv, spc); chk("lit_pc8", 64'(spc), 64'h008);
        chk("lit_drained", 64'(count), 64'd0);

        // Fill to capacity; a fifth offer is refused.
        for (int i = 0; i < 4; i++) step(1, $urandom, 20'(32'h10 + 4 * i), 0, 0, sv, spc);
        chk("lit_full_count", 64'(count),    64'd4);
        chk("lit_full_ready", 64'(in_ready), 64'd0);
        step(1, 32'hDEAD_BEEF, 20'h0FC, 1, 0, sv, spc);
        chk("lit_full_deq_count", 64'(count),    64'd3);
        chk("lit_full_deq_ready", 64'(in_ready), 64'd1);
        while (q.size() != 0) step(0, 0, 0, 1, 0, sv, spc);

        // Streaming: count stays constant, pointers wrap.
        for (int i = 0; i < 10; i++) step(1, $urandom, 20'(4 * i), 1, 0, sv, spc);
        chk("lit_stream_count", 64'(count), BYP ? 64'd0 : 64'd1);
        while (q.size() != 0) step(0, 0, 0, 1, 0, sv, spc);

        // Flush with a concurrent enqueue.
        for (int i = 0; i < 3; i++) step(1, $urandom, 20'(32'h200 + 4 * i), 0, 0, sv, spc);
        step(1, 32'h1234_5678, 20'h100, 0, 1, sv, spc);
        chk("lit_flush_count", 64'(count), 64'd0);
        step(0, 0, 0, 1, 0, sv, spc);
        chk("lit_flush_valid", 64'(sv), 64'd0);

        // Empty-queue latency.
        step(1, 32'h0000_0013, 20'h040, 1, 0, sv, spc);
        if (BYP) begin
            chk("lit_byp_pc",    64'(spc),   64'h040);
            chk("lit_byp_count", 64'(count), 64'd0);
        end else begin
            chk("lit_nobyp_v0", 64'(sv), 64'd0);
            step(0, 0, 0, 1, 0, sv, spc);
            chk("lit_nobyp_pc", 64'(spc), 64'h040);
        end
        while (q.size() != 0) step(0, 0, 0, 1, 0, sv, spc);

        // Asynchronous reset mid-stream with two entries held.
        step(1, $urandom, 20'h300, 0, 0, sv, spc);
        step(1, $urandom, 20'h304, 0, 0, sv, spc);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("lit_async_valid", 64'(out_valid), 64'd0);
        chk("lit_async_count", 64'(count),     64'd0);
        q.delete();
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 20'($urandom_range(0, 20'hFFFF) * 4),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, sv, spc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
